// File: rtl/riscv_alu_arbiter_if.sv
// Request/response bundle between two requesters and the ALU arbiter.
// Requester n owns bit n of each 2-bit field and slice n of each packed vector.
interface riscv_alu_arbiter_if #(
    parameter int TAG_W = 4
);
    logic [1:0]         req_valid_i;
    logic [1:0]         req_ready_o;
    logic [7:0]         req_op_i;
    logic [63:0]        req_a_i;
    logic [63:0]        req_b_i;
    logic [2*TAG_W-1:0] req_tag_i;

    logic [1:0]         rsp_valid_o;
    logic [1:0]         rsp_ready_i;
    logic [63:0]        rsp_result_o;
    logic [2*TAG_W-1:0] rsp_tag_o;
    logic [1:0]         rsp_err_o;

    // Requester side
    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o
    );

    // Arbiter side
    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o
    );
endinterface

// File: rtl/riscv_alu_arbiter.sv
// Two-requester round-robin arbiter time-sharing one combinational riscv_alu.
// Granted request -> issue register (drives the ALU) -> per-requester response
// register with valid/ready. Illegal op codes issue as OUT_ZERO and are flagged.
module riscv_alu_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 flush_i,
    riscv_alu_arbiter_if.slave   bus,
    output logic [3:0]           alu_op_o,
    output logic [31:0]          alu_a_o,
    output logic [31:0]          alu_b_o,
    input  logic [31:0]          alu_result_i
);
    localparam logic [3:0] OP_OUT_ZERO = 4'd7;
    localparam logic [3:0] OP_MAX      = 4'd10;

    // Issue stage
    logic             iss_valid_reg;
    logic             iss_id_reg;
    logic [3:0]       iss_op_reg;
    logic [31:0]      iss_a_reg;
    logic [31:0]      iss_b_reg;
    logic [TAG_W-1:0] iss_tag_reg;
    logic             iss_err_reg;
    logic             rr_reg;

    // Response slots
    logic [1:0]       rsp_valid_reg;
    logic [31:0]      rsp_result_reg [2];
    logic [TAG_W-1:0] rsp_tag_reg    [2];
    logic [1:0]       rsp_err_reg;

    logic [1:0]       busy;
    logic [1:0]       elig;
    logic [1:0]       grant;
    logic             winner;
    logic             accept;

    logic [3:0]       sel_op;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic [TAG_W-1:0] sel_tag;
    logic             sel_illegal;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            // A requester is busy while its op is in the issue stage or its
            // response slot is occupied and not being popped this cycle.
            assign busy[gi] = (iss_valid_reg && (iss_id_reg == 1'(gi)))
                            || (rsp_valid_reg[gi] && !bus.rsp_ready_i[gi]);
            assign elig[gi] = bus.req_valid_i[gi] && !busy[gi] && !flush_i && !rst_i;
        end
    endgenerate

    // Pick the winner: a lone eligible requester wins, a tie goes to rr_reg.
    always_comb begin
        winner = rr_reg;
        grant  = 2'b00;
        if (elig == 2'b01) begin
            winner = 1'b0;
        end else if (elig == 2'b10) begin
            winner = 1'b1;
        end
        if (elig != 2'b00) begin
            grant[winner] = 1'b1;
        end
    end

    assign accept          = |grant;
    assign bus.req_ready_o = grant;

    assign sel_op      = winner ? bus.req_op_i[7:4]   : bus.req_op_i[3:0];
    assign sel_a       = winner ? bus.req_a_i[63:32]  : bus.req_a_i[31:0];
    assign sel_b       = winner ? bus.req_b_i[63:32]  : bus.req_b_i[31:0];
    assign sel_tag     = winner ? bus.req_tag_i[2*TAG_W-1:TAG_W] : bus.req_tag_i[TAG_W-1:0];
    assign sel_illegal = (sel_op > OP_MAX);

    // Issue register and round-robin pointer. The issue stage never stalls:
    // the busy rule guarantees the destination response slot is free.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            iss_valid_reg <= 1'b0;
            iss_id_reg    <= 1'b0;
            iss_op_reg    <= 4'd0;
            iss_a_reg     <= 32'd0;
            iss_b_reg     <= 32'd0;
            iss_tag_reg   <= '0;
            iss_err_reg   <= 1'b0;
            rr_reg        <= 1'b0;
        end else if (flush_i) begin
            iss_valid_reg <= 1'b0;
        end else if (accept) begin
            iss_valid_reg <= 1'b1;
            iss_id_reg    <= winner;
            iss_op_reg    <= sel_illegal ? OP_OUT_ZERO : sel_op;
            iss_a_reg     <= sel_a;
            iss_b_reg     <= sel_b;
            iss_tag_reg   <= sel_tag;
            iss_err_reg   <= sel_illegal;
            rr_reg        <= ~winner;
        end else begin
            iss_valid_reg <= 1'b0;
        end
    end

    assign alu_op_o = iss_op_reg;
    assign alu_a_o  = iss_a_reg;
    assign alu_b_o  = iss_b_reg;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            logic capture;
            assign capture = iss_valid_reg && (iss_id_reg == 1'(gi));

            // Capture the ALU result for this requester, or pop it when taken.
            // Flush drops anything in flight, including a capture on this edge.
            always_ff @(posedge clk) begin
                if (rst_i) begin
                    rsp_valid_reg[gi]  <= 1'b0;
                    rsp_result_reg[gi] <= 32'd0;
                    rsp_tag_reg[gi]    <= '0;
                    rsp_err_reg[gi]    <= 1'b0;
                end else if (flush_i) begin
                    rsp_valid_reg[gi]  <= 1'b0;
                end else if (capture) begin
                    rsp_valid_reg[gi]  <= 1'b1;
                    rsp_result_reg[gi] <= alu_result_i;
                    rsp_tag_reg[gi]    <= iss_tag_reg;
                    rsp_err_reg[gi]    <= iss_err_reg;
                end else if (rsp_valid_reg[gi] && bus.rsp_ready_i[gi]) begin
                    rsp_valid_reg[gi]  <= 1'b0;
                end
            end

            assign bus.rsp_result_o[32*gi +: 32]   = rsp_result_reg[gi];
            assign bus.rsp_tag_o[TAG_W*gi +: TAG_W] = rsp_tag_reg[gi];
        end
    endgenerate

    assign bus.rsp_valid_o = rsp_valid_reg;
    assign bus.rsp_err_o   = rsp_err_reg;
endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Directed bench for riscv_alu_arbiter with a behavioural riscv_alu attached.
module tb_riscv_alu_arbiter;
    localparam int TAG_W = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [31:0] alu_result_i;

    int tests_run    = 0;
    int tests_failed = 0;

    riscv_alu_arbiter_if #(.TAG_W(TAG_W)) bus ();

    riscv_alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .bus          (bus),
        .alu_op_o     (alu_op_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_result_i (alu_result_i)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational riscv_alu
    always_comb begin
        case (alu_op_o)
            4'd0:    alu_result_i = alu_a_o + alu_b_o;
            4'd1:    alu_result_i = alu_a_o & alu_b_o;
            4'd2:    alu_result_i = alu_a_o << alu_b_o[4:0];
            4'd3:    alu_result_i = alu_a_o >> alu_b_o[4:0];
            4'd4:    alu_result_i = alu_a_o | alu_b_o;
            4'd5:    alu_result_i = alu_a_o ^ alu_b_o;
            4'd6:    alu_result_i = 32'd1;
            4'd7:    alu_result_i = 32'd0;
            4'd8:    alu_result_i = 32'($signed(alu_a_o) >>> alu_b_o[4:0]);
            4'd9:    alu_result_i = alu_b_o;
            4'd10:   alu_result_i = alu_a_o - alu_b_o;
            default: alu_result_i = 32'd0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag);
        bus.req_valid_i[n]            = v;
        bus.req_op_i[4*n +: 4]        = op;
        bus.req_a_i[32*n +: 32]       = a;
        bus.req_b_i[32*n +: 32]       = b;
        bus.req_tag_i[TAG_W*n +: TAG_W] = tag;
    endtask

    initial begin
        rst_i            = 1'b1;
        flush_i          = 1'b0;
        bus.req_valid_i  = 2'b00;
        bus.req_op_i     = '0;
        bus.req_a_i      = '0;
        bus.req_b_i      = '0;
        bus.req_tag_i    = '0;
        bus.rsp_ready_i  = 2'b11;

        // Reset: ready stays low while reset is high, state clears
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd1, 4'd1);
        #1;
        check_eq("rst_ready", 64'(bus.req_ready_o), 64'h0);
        tick();
        tick();
        rst_i = 1'b0;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        #1;
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
        check_eq("rst_alu_op", 64'(alu_op_o), 64'h0);
        check_eq("rst_rsp_result", bus.rsp_result_o, 64'h0);

        // Single ADD from requester 0
        set_req(0, 1'b1, 4'd0, 32'd5, 32'd7, 4'd3);
        #1;
        check_eq("t1_grant", 64'(bus.req_ready_o), 64'h1);
        tick();
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        #1;
        check_eq("t1_alu_op", 64'(alu_op_o), 64'h0);
        check_eq("t1_alu_a", 64'(alu_a_o), 64'd5);
        check_eq("t1_alu_b", 64'(alu_b_o), 64'd7);
        check_eq("t1_no_rsp_yet", 64'(bus.rsp_valid_o), 64'h0);
        tick();
        check_eq("t1_rsp_valid", 64'(bus.rsp_valid_o), 64'h1);
        check_eq("t1_result", 64'(bus.rsp_result_o[31:0]), 64'd12);
        check_eq("t1_tag", 64'(bus.rsp_tag_o[3:0]), 64'd3);
        check_eq("t1_err", 64'(bus.rsp_err_o[0]), 64'd0);
        tick();
        check_eq("t1_rsp_pop", 64'(bus.rsp_valid_o), 64'h0);

        // Reset pulse puts rr back to 0
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;

        // Contention: both requesters valid, responses always ready
        set_req(0, 1'b1, 4'd10, 32'd10, 32'd3, 4'd1);
        set_req(1, 1'b1, 4'd5, 32'h0000_00F0, 32'h0000_000F, 4'd2);
        for (int i = 0; i < 8; i++) begin
            #1;
            check_eq($sformatf("t2_grant_c%0d", i), 64'(bus.req_ready_o),
                     (i % 2 == 0) ? 64'h1 : 64'h2);
            if (i >= 2) begin
                check_eq($sformatf("t2_rsp_valid_c%0d", i), 64'(bus.rsp_valid_o),
                         (i % 2 == 0) ? 64'h1 : 64'h2);
                if (i % 2 == 0)
                    check_eq($sformatf("t2_r0_result_c%0d", i), 64'(bus.rsp_result_o[31:0]), 64'd7);
                else
                    check_eq($sformatf("t2_r1_result_c%0d", i), 64'(bus.rsp_result_o[63:32]), 64'hFF);
            end
            tick();
        end
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        tick();
        tick();
        tick();

        // Backpressure on requester 0 while requester 1 keeps going
        set_req(0, 1'b1, 4'd2, 32'd1, 32'd4, 4'd5);
        #1;
        check_eq("t3_grant_r0", 64'(bus.req_ready_o), 64'h1);
        tick();
        bus.rsp_ready_i = 2'b10;
        set_req(1, 1'b1, 4'd5, 32'h0000_00F0, 32'h0000_000F, 4'd6);
        for (int i = 1; i <= 5; i++) begin
            #1;
            check_eq($sformatf("t3_ready_b%0d", i), 64'(bus.req_ready_o),
                     (i % 2 == 1) ? 64'h2 : 64'h0);
            if (i >= 2) begin
                check_eq($sformatf("t3_r0_held_b%0d", i), 64'(bus.rsp_valid_o[0]), 64'h1);
                check_eq($sformatf("t3_r0_result_b%0d", i), 64'(bus.rsp_result_o[31:0]), 64'd16);
            end
            tick();
        end
        bus.rsp_ready_i = 2'b11;
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        #1;
        check_eq("t3_pop_regrant", 64'(bus.req_ready_o), 64'h1);
        check_eq("t3_pop_tag", 64'(bus.rsp_tag_o[3:0]), 64'd5);
        tick();
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        #1;
        check_eq("t3_after_pop", 64'(bus.rsp_valid_o), 64'h2);
        tick();
        check_eq("t3_reissue", 64'(bus.rsp_valid_o), 64'h1);
        check_eq("t3_reissue_result", 64'(bus.rsp_result_o[31:0]), 64'd16);
        tick();
        tick();

        // Illegal op from requester 1
        set_req(1, 1'b1, 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9);
        #1;
        check_eq("t4_grant_r1", 64'(bus.req_ready_o), 64'h2);
        tick();
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        #1;
        check_eq("t4_alu_op", 64'(alu_op_o), 64'd7);
        tick();
        check_eq("t4_rsp_valid", 64'(bus.rsp_valid_o), 64'h2);
        check_eq("t4_result", 64'(bus.rsp_result_o[63:32]), 64'd0);
        check_eq("t4_err", 64'(bus.rsp_err_o), 64'h2);
        check_eq("t4_tag", 64'(bus.rsp_tag_o[7:4]), 64'd9);
        tick();

        // Flush mid-flight: no response, rr kept (r0 accepted so rr=1)
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd2, 4'd4);
        #1;
        check_eq("t5_grant_r0", 64'(bus.req_ready_o), 64'h1);
        tick();
        flush_i = 1'b1;
        set_req(1, 1'b1, 4'd5, 32'd3, 32'd1, 4'd8);
        #1;
        check_eq("t5_flush_ready", 64'(bus.req_ready_o), 64'h0);
        tick();
        flush_i = 1'b0;
        #1;
        check_eq("t5_no_rsp", 64'(bus.rsp_valid_o), 64'h0);
        check_eq("t5_rr_kept", 64'(bus.req_ready_o), 64'h2);
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        tick();
        check_eq("t5_no_rsp_late", 64'(bus.rsp_valid_o), 64'h0);
        tick();

        // Reset together with flush mid-flight
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd2, 4'd4);
        #1;
        check_eq("t6_grant_r0", 64'(bus.req_ready_o), 64'h1);
        tick();
        rst_i   = 1'b1;
        flush_i = 1'b1;
        set_req(1, 1'b1, 4'd5, 32'd3, 32'd1, 4'd8);
        #1;
        check_eq("t6_rst_ready", 64'(bus.req_ready_o), 64'h0);
        tick();
        rst_i   = 1'b0;
        flush_i = 1'b0;
        #1;
        check_eq("t6_alu_a", 64'(alu_a_o), 64'd0);
        check_eq("t6_alu_b", 64'(alu_b_o), 64'd0);
        check_eq("t6_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
        check_eq("t6_rsp_tag", 64'(bus.rsp_tag_o), 64'h0);
        check_eq("t6_rr_zero", 64'(bus.req_ready_o), 64'h1);
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        tick();
        tick();
        check_eq("t6_no_rsp", 64'(bus.rsp_valid_o), 64'h0);

        // SRA passes through the ALU result untouched
        set_req(0, 1'b1, 4'd8, 32'h8000_0000, 32'h0000_0024, 4'd7);
        #1;
        check_eq("t7_grant_r0", 64'(bus.req_ready_o), 64'h1);
        tick();
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        #1;
        check_eq("t7_alu_op", 64'(alu_op_o), 64'd8);
        tick();
        check_eq("t7_rsp_valid", 64'(bus.rsp_valid_o), 64'h1);
        check_eq("t7_result", 64'(bus.rsp_result_o[31:0]), 64'hF800_0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
